frame_codec: RTL and testbench

Parametrised byte-level frame engine for the motor board RS485 link. It sits between a UART byte receiver/transmitter pair and the control core, and replaces the fixed-layout command/status decoder with a generic one.
- Hunts for magic numbers, receives addressed frames, and checks CRC-16 incrementally per byte.
- Publishes command payloads.
- Answers status requests with a snapshot of N 32-bit status words.
- Adds a frame timeout, error counting, and a proper byte handshake to the transmitter.

---
 rtl/frame_codec.sv | 217 +++++++++++++++++++++
 tb/tb_frame_codec.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/frame_codec.sv
// rtl/frame_codec.sv - RS485 frame engine: magic hunt, CRC-16 check, command publish, status response
// Optional feature macro: FRAME_CODEC_ACK_EN (one-byte 8'h00 ack after commands addressed to our own ID)
module frame_codec #(
  parameter int          NUM_STATUS_WORDS  = 6,
  parameter int          CMD_PAYLOAD_BYTES = 28,
  parameter logic [31:0] CMD_MAGIC         = 32'hBAADA555,
  parameter logic [31:0] REQ_MAGIC         = 32'h1CE1CEBB,
  parameter logic [31:0] STATUS_MAGIC      = 32'h1CEB00DA,
  parameter int          TIMEOUT_CYCLES    = 100000,
  parameter logic [7:0]  BROADCAST_ID      = 8'hFF
) (
  input  logic                              i_clk,
  input  logic                              i_rst,
  input  logic                              i_rx_valid,
  input  logic [7:0]                        i_rx_data,
  output logic                              o_tx_start,
  output logic [7:0]                        o_tx_data,
  input  logic                              i_tx_busy,
  input  logic [7:0]                        i_id,
  input  logic [32*NUM_STATUS_WORDS-1:0]    i_status_words,
  output logic [8*CMD_PAYLOAD_BYTES-1:0]    o_cmd_payload,
  output logic                              o_cmd_valid,
  output logic [15:0]                       o_crc_err_count,
  output logic [15:0]                       o_timeout_count,
  output logic                              o_busy
);
  localparam int RESP_LEN = 7 + 4*NUM_STATUS_WORDS;
  localparam int CMD_LEN  = CMD_PAYLOAD_BYTES + 3;
  localparam int MAX_LEN  = (RESP_LEN > CMD_LEN) ? RESP_LEN : CMD_LEN;
  localparam int IDX_W    = $clog2(MAX_LEN + 1);
  localparam int TMR_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam int PL_W     = 8*CMD_PAYLOAD_BYTES;
  localparam int SW_W     = 32*NUM_STATUS_WORDS;
  // Byte index of the last received byte / first received CRC byte (index 0 is the ID)
  localparam logic [IDX_W-1:0] CMD_LAST      = IDX_W'(CMD_LEN - 1);
  localparam logic [IDX_W-1:0] REQ_LAST      = IDX_W'(2);
  localparam logic [IDX_W-1:0] CMD_CRC_FIRST = IDX_W'(CMD_PAYLOAD_BYTES + 1);
  localparam logic [IDX_W-1:0] REQ_CRC_FIRST = IDX_W'(1);
  // Response byte indices: 0..3 magic, 4 ID, 5..CRC_END_TX status, then CRC high/low
  localparam logic [IDX_W-1:0] CRC_END_TX    = IDX_W'(4 + 4*NUM_STATUS_WORDS);
  localparam logic [IDX_W-1:0] RESP_LAST     = IDX_W'(RESP_LEN - 1);
  localparam logic [TMR_W-1:0] TMR_LAST      = TMR_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {S_IDLE, S_RX_BODY, S_CHECK, S_TX_LOAD, S_TX_SEND, S_TX_WAIT} state_t;

  state_t             r_state, w_next;
  logic [31:0]        r_magic;
  logic               r_is_cmd;
  logic [IDX_W-1:0]   r_idx;
  logic [15:0]        r_crc;
  logic [15:0]        r_rx_crc;
  logic [7:0]         r_rx_id;
  logic [PL_W-1:0]    r_pl;
  logic [TMR_W-1:0]   r_tmr;
  logic [SW_W-1:0]    r_snap;
  logic               r_ack;
  logic               r_wait_first;
  logic               r_tx_start;
  logic [7:0]         r_tx_data;
  logic [PL_W-1:0]    r_cmd_payload;
  logic               r_cmd_valid;
  logic [15:0]        r_crc_err;
  logic [15:0]        r_tmo;

  logic               w_magic_hit, w_timeout, w_crc_ok, w_own, w_bcast;
  logic               w_accept_cmd, w_answer_req, w_ack_go, w_tx_last;
  logic [IDX_W-1:0]   w_crc_first, w_rx_last;
  logic [7:0]         w_resp_byte;
  int                 w_sb;

  // CRC-16 poly 0x8005, MSB-first, one byte per call
  function automatic logic [15:0] crc_step(input logic [15:0] c, input logic [7:0] d);
    logic [15:0] r;
    r = c;
    for (int i = 7; i >= 0; i--) begin
      if (r[15] ^ d[i]) r = {r[14:0], 1'b0} ^ 16'h8005;
      else              r = {r[14:0], 1'b0};
    end
    return r;
  endfunction

  assign w_magic_hit  = (r_magic == CMD_MAGIC) || (r_magic == REQ_MAGIC);
  assign w_crc_first  = r_is_cmd ? CMD_CRC_FIRST : REQ_CRC_FIRST;
  assign w_rx_last    = r_is_cmd ? CMD_LAST : REQ_LAST;
  assign w_timeout    = !i_rx_valid && (r_tmr == TMR_LAST);
  assign w_crc_ok     = (r_crc == r_rx_crc);
  assign w_own        = (r_rx_id == i_id);
  assign w_bcast      = (r_rx_id == BROADCAST_ID);
  assign w_accept_cmd = w_crc_ok && r_is_cmd && (w_own || w_bcast);
  assign w_answer_req = w_crc_ok && !r_is_cmd && w_own;
`ifdef FRAME_CODEC_ACK_EN
  assign w_ack_go     = w_accept_cmd && w_own;
`else
  assign w_ack_go     = 1'b0;
`endif
  assign w_tx_last    = r_ack || (r_idx == RESP_LAST);

  assign o_tx_start      = r_tx_start;
  assign o_tx_data       = r_tx_data;
  assign o_cmd_payload   = r_cmd_payload;
  assign o_cmd_valid     = r_cmd_valid;
  assign o_crc_err_count = r_crc_err;
  assign o_timeout_count = r_tmo;
  assign o_busy          = (r_state != S_IDLE);

  // Response byte selected by r_idx; the ack byte is always zero
  always_comb begin
    w_sb        = int'(r_idx) - 5;
    w_resp_byte = 8'h00;
    if (r_ack)                      w_resp_byte = 8'h00;
    else if (r_idx < IDX_W'(4))     w_resp_byte = STATUS_MAGIC[8*(3 - int'(r_idx)) +: 8];
    else if (r_idx == IDX_W'(4))    w_resp_byte = r_rx_id;
    else if (r_idx <= CRC_END_TX)   w_resp_byte = r_snap[32*(w_sb/4) + 8*(3 - w_sb%4) +: 8];
    else if (r_idx == RESP_LAST)    w_resp_byte = r_crc[7:0];
    else                            w_resp_byte = r_crc[15:8];
  end

  // State register
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:    if (w_magic_hit) w_next = S_RX_BODY;
      S_RX_BODY: begin
        if (i_rx_valid && (r_idx == w_rx_last)) w_next = S_CHECK;
        else if (w_timeout)                     w_next = S_IDLE;
      end
      S_CHECK: begin
        if (w_answer_req)  w_next = S_TX_LOAD;
        else if (w_ack_go) w_next = S_TX_SEND;
        else               w_next = S_IDLE;
      end
      S_TX_LOAD: if (r_idx == CRC_END_TX) w_next = S_TX_SEND;
      S_TX_SEND: w_next = S_TX_WAIT;
      S_TX_WAIT: if (!r_wait_first && !i_tx_busy) w_next = w_tx_last ? S_IDLE : S_TX_SEND;
      default:   w_next = S_IDLE;
    endcase
  end

  // Datapath: magic hunt, byte capture, CRC, counters, transmit registers
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_magic <= '0;  r_is_cmd <= 1'b0;  r_idx <= '0;  r_crc <= 16'hFFFF;
      r_rx_crc <= '0; r_rx_id <= '0;     r_pl <= '0;   r_tmr <= '0;
      r_snap <= '0;   r_ack <= 1'b0;     r_wait_first <= 1'b0;
      r_tx_start <= 1'b0; r_tx_data <= '0; r_cmd_payload <= '0; r_cmd_valid <= 1'b0;
      r_crc_err <= '0; r_tmo <= '0;
    end else begin
      r_tx_start  <= 1'b0;
      r_cmd_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_magic_hit) begin
            r_is_cmd <= (r_magic == CMD_MAGIC);
            r_magic  <= '0;
            r_idx    <= '0;
            r_crc    <= 16'hFFFF;
            r_tmr    <= '0;
            r_ack    <= 1'b0;
          end else if (i_rx_valid) begin
            r_magic <= {r_magic[23:0], i_rx_data};
          end
        end
        S_RX_BODY: begin
          if (i_rx_valid) begin
            r_tmr <= '0;
            r_idx <= r_idx + 1'b1;
            if (r_idx < w_crc_first) begin
              r_crc <= crc_step(r_crc, i_rx_data);
              if (r_idx == '0) r_rx_id <= i_rx_data;
              else             r_pl    <= {r_pl[PL_W-9:0], i_rx_data};
            end else begin
              r_rx_crc <= {r_rx_crc[7:0], i_rx_data};
            end
          end else if (w_timeout) begin
            r_tmo <= (r_tmo == 16'hFFFF) ? r_tmo : r_tmo + 1'b1;
          end else begin
            r_tmr <= r_tmr + 1'b1;
          end
        end
        S_CHECK: begin
          r_idx <= '0;
          if (!w_crc_ok) r_crc_err <= (r_crc_err == 16'hFFFF) ? r_crc_err : r_crc_err + 1'b1;
          if (w_accept_cmd) begin
            r_cmd_payload <= r_pl;
            r_cmd_valid   <= 1'b1;
            r_ack         <= w_ack_go;
          end
          if (w_answer_req) begin
            r_snap <= i_status_words;
            r_idx  <= IDX_W'(4);
            r_crc  <= 16'hFFFF;
          end
        end
        S_TX_LOAD: begin
          r_crc <= crc_step(r_crc, w_resp_byte);
          r_idx <= (r_idx == CRC_END_TX) ? '0 : r_idx + 1'b1;
        end
        S_TX_SEND: begin
          r_tx_start   <= 1'b1;
          r_tx_data    <= w_resp_byte;
          r_wait_first <= 1'b1;
        end
        S_TX_WAIT: begin
          r_wait_first <= 1'b0;
          if (!r_wait_first && !i_tx_busy && !w_tx_last) r_idx <= r_idx + 1'b1;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_frame_codec.sv
// tb/tb_frame_codec.sv - self-checking bench for frame_codec with a queue-based reference model
module tb_frame_codec;
  localparam int NSW = 2;
  localparam int NPL = 8;
  localparam int TMO = 50;
  localparam logic [31:0] CMD_M = 32'hBAADA555;
  localparam logic [31:0] REQ_M = 32'h1CE1CEBB;
  localparam logic [31:0] STA_M = 32'h1CEB00DA;

  logic              clk = 1'b0;
  logic              rst;
  logic              i_rx_valid;
  logic [7:0]        i_rx_data;
  logic              o_tx_start;
  logic [7:0]        o_tx_data;
  logic              i_tx_busy = 1'b0;
  logic [7:0]        i_id;
  logic [32*NSW-1:0] i_status_words;
  logic [8*NPL-1:0]  o_cmd_payload;
  logic              o_cmd_valid;
  logic [15:0]       o_crc_err_count;
  logic [15:0]       o_timeout_count;
  logic              o_busy;

  always #5 clk = ~clk;

  frame_codec #(.NUM_STATUS_WORDS(NSW), .CMD_PAYLOAD_BYTES(NPL), .TIMEOUT_CYCLES(TMO)) dut (
    .i_clk(clk), .i_rst(rst), .i_rx_valid(i_rx_valid), .i_rx_data(i_rx_data),
    .o_tx_start(o_tx_start), .o_tx_data(o_tx_data), .i_tx_busy(i_tx_busy), .i_id(i_id),
    .i_status_words(i_status_words), .o_cmd_payload(o_cmd_payload), .o_cmd_valid(o_cmd_valid),
    .o_crc_err_count(o_crc_err_count), .o_timeout_count(o_timeout_count), .o_busy(o_busy));

  int          n_vec = 0;
  int          n_err = 0;
  int          cmd_cnt = 0;
  int          busy_left = 0;
  int          busy_viol = 0;
  logic [63:0] last_pl = '0;
  logic [7:0]  tx_q[$];

  // UART model: capture bytes, hold busy for 3 cycles after every start pulse
  always @(negedge clk) begin
    if (o_cmd_valid) begin cmd_cnt++; last_pl = o_cmd_payload; end
    if (o_tx_start) begin
      if (i_tx_busy) busy_viol++;
      tx_q.push_back(o_tx_data);
      busy_left = 3;
    end else if (busy_left > 0) begin
      busy_left--;
    end
    i_tx_busy = (busy_left > 0);
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // CRC as polynomial remainder: init folded into the first 16 bits, message augmented by 16 zeros
  function automatic logic [15:0] crc_model(input logic [7:0] msg[$]);
    logic bits[$];
    logic [16:0] gen;
    logic [15:0] rem;
    gen = 17'h18005;
    foreach (msg[k]) for (int b = 7; b >= 0; b--) bits.push_back(msg[k][b]);
    for (int i = 0; i < 16; i++) bits.push_back(1'b0);
    for (int i = 0; i < 16; i++) bits[i] = ~bits[i];
    for (int i = 0; i + 16 < bits.size(); i++)
      if (bits[i]) for (int j = 0; j < 17; j++) bits[i+j] = bits[i+j] ^ gen[16-j];
    for (int j = 0; j < 16; j++) rem[15-j] = bits[bits.size()-16+j];
    return rem;
  endfunction

  function automatic logic [63:0] pack(input logic [7:0] q[$]);
    logic [63:0] v = '0;
    foreach (q[k]) v = {v[55:0], q[k]};
    return v;
  endfunction

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(posedge clk); #1; i_rx_valid = 1'b1; i_rx_data = b;
    @(posedge clk); #1; i_rx_valid = 1'b0;
    repeat ($urandom_range(1, 3)) @(posedge clk);
  endtask

  task automatic send_frame(input logic [31:0] magic, input logic [7:0] id,
                            input logic [7:0] body[$], input logic [15:0] crc_flip);
    logic [7:0]  cov[$];
    logic [15:0] c;
    cov = body;
    cov.push_front(id);
    c = crc_model(cov) ^ crc_flip;
    for (int i = 3; i >= 0; i--) send_byte(magic[8*i +: 8]);
    foreach (cov[k]) send_byte(cov[k]);
    send_byte(c[15:8]);
    send_byte(c[7:0]);
  endtask

  // Expected response: magic, ID, words (word 0 first, MSB first), CRC over ID..last status byte
  task automatic check_response(input string tag, input logic [7:0] id, input logic [32*NSW-1:0] sw);
    logic [7:0]  exp_q[$];
    logic [7:0]  cov[$];
    logic [15:0] c;
    int          t;
    cov.push_back(id);
    for (int w = 0; w < NSW; w++)
      for (int b = 3; b >= 0; b--) cov.push_back(sw[32*w + 8*b +: 8]);
    c = crc_model(cov);
    for (int i = 3; i >= 0; i--) exp_q.push_back(STA_M[8*i +: 8]);
    foreach (cov[k]) exp_q.push_back(cov[k]);
    exp_q.push_back(c[15:8]);
    exp_q.push_back(c[7:0]);
    t = 0;
    while (tx_q.size() < exp_q.size() && t < 4000) begin @(posedge clk); t++; end
    idle(20);
    check({tag, "_len"}, 64'(tx_q.size()), 64'(exp_q.size()));
    foreach (exp_q[k]) if (k < tx_q.size()) check($sformatf("%s_b%0d", tag, k), 64'(tx_q[k]), 64'(exp_q[k]));
    check({tag, "_busy"}, 64'(o_busy), 64'd0);
  endtask

  initial begin
    logic [7:0]  raw[$];
    logic [7:0]  pl[$];
    logic [7:0]  prev[$];
    logic [7:0]  none[$];
    logic [7:0]  dst;
    logic [63:0] exp_pl;
    int          exp_cnt;
    int          exp_crc;
    int          t;

    rst = 1'b1; i_rx_valid = 1'b0; i_rx_data = '0; i_id = 8'h31; i_status_words = '0;
    idle(3);
    check("rst_tx_start", 64'(o_tx_start), 64'd0);
    check("rst_tx_data", 64'(o_tx_data), 64'd0);
    check("rst_payload", o_cmd_payload, 64'd0);
    check("rst_cmd_valid", 64'(o_cmd_valid), 64'd0);
    check("rst_crc_err", 64'(o_crc_err_count), 64'd0);
    check("rst_timeout", 64'(o_timeout_count), 64'd0);
    check("rst_busy", 64'(o_busy), 64'd0);
    rst = 1'b0;
    idle(3);

    // Known-answer frame: "123456789" with CRC AE E7
    raw = '{8'hBA, 8'hAD, 8'hA5, 8'h55, 8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39, 8'hAE, 8'hE7};
    foreach (raw[k]) send_byte(raw[k]);
    idle(5);
    check("kat_cmd_cnt", 64'(cmd_cnt), 64'd1);
    check("kat_payload", o_cmd_payload, 64'h3233343536373839);
    check("kat_crc_err", 64'(o_crc_err_count), 64'd0);
    raw[14] = 8'hE6;
    foreach (raw[k]) send_byte(raw[k]);
    idle(5);
    check("bad_cmd_cnt", 64'(cmd_cnt), 64'd1);
    check("bad_crc_err", 64'(o_crc_err_count), 64'd1);
    check("bad_payload", o_cmd_payload, 64'h3233343536373839);
    exp_cnt = 1; exp_crc = 1; exp_pl = 64'h3233343536373839;

    // Random commands: own ID, broadcast, foreign ID; magic-valued payload; repeated payload
    for (int it = 0; it < 7; it++) begin
      pl.delete();
      for (int k = 0; k < NPL; k++) pl.push_back(8'($urandom_range(0, 255)));
      if (it == 2) begin
        for (int k = 0; k < 4; k++) pl[k] = CMD_M[8*(3-k) +: 8];
        for (int k = 0; k < 4; k++) pl[4+k] = REQ_M[8*(3-k) +: 8];
      end
      if (it == 4) pl = prev;
      case (it % 3)
        0:       dst = i_id;
        1:       dst = 8'hFF;
        default: begin
          dst = 8'($urandom_range(0, 255));
          while (dst == i_id || dst == 8'hFF) dst = dst + 8'd1;
        end
      endcase
      if (it == 4) dst = i_id;
      send_frame(CMD_M, dst, pl, 16'h0000);
      idle(5);
      if (dst == i_id || dst == 8'hFF) begin exp_cnt++; exp_pl = pack(pl); prev = pl; end
      check($sformatf("rnd%0d_cmd_cnt", it), 64'(cmd_cnt), 64'(exp_cnt));
      check($sformatf("rnd%0d_payload", it), o_cmd_payload, exp_pl);
      check($sformatf("rnd%0d_crc_err", it), 64'(o_crc_err_count), 64'(exp_crc));
    end

    // Fixed status request
    i_id = 8'h05; i_status_words = {32'h00000002, 32'h00000001};
    tx_q.delete();
    send_frame(REQ_M, 8'h05, none, 16'h0000);
    check_response("req_fixed", 8'h05, {32'h00000002, 32'h00000001});

    // Random status request
    i_id = 8'($urandom_range(0, 254));
    i_status_words = {$urandom, $urandom};
    tx_q.delete();
    send_frame(REQ_M, i_id, none, 16'h0000);
    check_response("req_rand", i_id, i_status_words);

    // Broadcast request is never answered; corrupted request only counts an error
    tx_q.delete();
    send_frame(REQ_M, 8'hFF, none, 16'h0000);
    idle(200);
    check("req_bcast_tx", 64'(tx_q.size()), 64'd0);
    send_frame(REQ_M, i_id, none, 16'h0100);
    idle(200);
    exp_crc++;
    check("req_badcrc_tx", 64'(tx_q.size()), 64'd0);
    check("req_badcrc_cnt", 64'(o_crc_err_count), 64'(exp_crc));
    check("req_cmd_cnt", 64'(cmd_cnt), 64'(exp_cnt));

    // Inter-byte timeout, then recovery
    for (int i = 3; i >= 0; i--) send_byte(CMD_M[8*i +: 8]);
    send_byte(8'h05); send_byte(8'h11); send_byte(8'h22);
    idle(40);
    check("tmo_busy_early", 64'(o_busy), 64'd1);
    idle(20);
    check("tmo_count", 64'(o_timeout_count), 64'd1);
    check("tmo_busy", 64'(o_busy), 64'd0);
    pl.delete();
    for (int k = 0; k < NPL; k++) pl.push_back(8'($urandom_range(0, 255)));
    send_frame(CMD_M, i_id, pl, 16'h0000);
    idle(5);
    exp_cnt++;
    check("tmo_after_cnt", 64'(cmd_cnt), 64'(exp_cnt));
    check("tmo_after_pl", o_cmd_payload, pack(pl));

    // Reset during the sixth response byte
    tx_q.delete();
    send_frame(REQ_M, i_id, none, 16'h0000);
    t = 0;
    while (tx_q.size() < 6 && t < 4000) begin @(posedge clk); t++; end
    #1;
    check("mid_reached", 64'(tx_q.size()), 64'd6);
    rst = 1'b1;
    idle(2);
    check("mid_rst_start", 64'(o_tx_start), 64'd0);
    check("mid_rst_busy", 64'(o_busy), 64'd0);
    check("mid_rst_crc", 64'(o_crc_err_count), 64'd0);
    check("mid_rst_tmo", 64'(o_timeout_count), 64'd0);
    check("mid_rst_pl", o_cmd_payload, 64'd0);
    rst = 1'b0;
    idle(30);
    check("mid_no_resume", 64'(tx_q.size()), 64'd6);
    tx_q.delete();
    send_frame(REQ_M, i_id, none, 16'h0000);
    check_response("req_after_rst", i_id, i_status_words);

    check("no_start_while_busy", 64'(busy_viol), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
